decoder_stream: RTL
===================

Name: decoder_stream

Overview:
- Parametrised, registered binary-to-N decoder with valid/ready streaming on both sides.
- Supports one-hot, thermometer and active-low one-hot modes, range-error tagging, a 2-entry skid buffer, a beat counter and a sticky error flag.
- Sits between a command/index producer and downstream select/enable fabric, where the old combinational decoder cannot meet timing or handle backpressure.

Parameters:
- IN_W, 4, binary index width.
- OUT_W, 16, decoded output width; legal range 2 <= OUT_W <= 2**IN_W.
- CNT_W, 16, width of the output beat counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat (registered).
- binary_in  input  IN_W  index to decode.
- enable  input  1  per-beat enable; 0 forces a zero output word.
- mode  input  2  per-beat mode: 00 one-hot, 01 thermometer, 10 active-low one-hot, 11 reserved.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- decoder_out  output  OUT_W  decoded word.
- range_err  output  1  the current output beat had an invalid index or mode.
- beat_cnt  output  CNT_W  count of completed output transfers.
- err_sticky  output  1  latched error status.
- err_clr  input  1  clears err_sticky.

Behaviour:
- Transfers: input when in_valid && in_ready; output when out_valid && out_ready.
- Decode is combinational on the input-side fields and is captured at the input transfer. All outputs are registered. Latency is 1 cycle from input transfer to out_valid when the block is empty.
- Decode rules, evaluated with i = binary_in:
  - enable=0: word = 0 (or all-ones in mode 10), range_err=0. The beat is still produced.
  - i >= OUT_W: word = 0 (all-ones in mode 10), range_err=1.
  - mode 00: bit i set, all others clear.
  - mode 01: bits [i:0] set, all others clear.
  - mode 10: bit i clear, all others set.
  - mode 11: decoded as mode 00, range_err=1.
- Storage: output register (OR) plus skid register (SR). Occupancy FSM has three states:
  - EMPTY: input transfer -> ONE (beat to OR).
  - ONE:
    - input and output transfer together -> ONE (new beat to OR).
    - input only -> TWO (beat to SR).
    - output only -> EMPTY.
  - TWO: output transfer -> ONE (SR moves to OR). No input transfer is possible in TWO.
- in_ready is 0 in TWO and 1 in EMPTY and ONE. It is registered, so it falls the cycle after entry to TWO and rises the cycle after leaving TWO.
- out_valid is 1 in ONE and TWO.
- decoder_out and range_err hold stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- beat_cnt increments on each output transfer and wraps from 2**CNT_W-1 to 0.
- err_sticky:
  - Set on an output transfer with range_err=1.
  - Cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
- Reset, asynchronous, also mid-operation:
  - in_ready=0, out_valid=0, decoder_out=0, range_err=0, beat_cnt=0, err_sticky=0, FSM=EMPTY.
  - Buffered beats are discarded.
  - in_ready goes to 1 on the first clock edge after rst_n deasserts.
- Inputs are ignored while in_ready=0.

Test Plan:
- Default parameters, out_ready=1, mode 00, enable=1, binary_in swept 0..15 back-to-back:
  - decoder_out = 0x0001, 0x0002 ... 0x8000, each one cycle after its input.
  - in_ready stays 1; beat_cnt=16 at the end.
- Mode 01 with binary_in=5 -> 0x003F. Mode 10 with binary_in=5 -> 0xFFDF. enable=0 in mode 00 -> 0x0000, range_err=0.
- OUT_W=10 instance:
  - binary_in=12 -> decoder_out=0, range_err=1, err_sticky=1 after the transfer.
  - err_clr coincident with a new error transfer -> err_sticky stays 1.
- Backpressure: hold out_ready=0 and offer 3 beats (idx 1, 2, 3):
  - Two beats are accepted; in_ready=0 from the cycle after the 2nd accept; the 3rd beat is held.
  - Release out_ready -> outputs 0x0002, 0x0004, 0x0008 in order, with no loss.
- Mode 11 with binary_in=2 -> decoder_out=0x0004, range_err=1.
- Reset mid-operation with the block in TWO:
  - All outputs go to reset values immediately; the buffered beats never appear.
  - in_ready=1 one clock after rst_n rises.
- CNT_W=3: after 9 output transfers, beat_cnt=1 (wrap).

Source files
------------

// File: rtl/decoder_stream.sv
// decoder_stream: registered binary-to-N decoder (one-hot/thermometer/active-low) with valid/ready,
// a 2-entry skid buffer, beat counter and sticky range-error flag.
module decoder_stream #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  binary_in,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] decoder_out,
  output logic             range_err,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             err_sticky,
  input  logic             err_clr
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q, state_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_word_q, out_word_d, sr_word_q, sr_word_d;
  logic [OUT_W-1:0] oh, therm, raw, dec_word;
  logic out_err_q, out_err_d, sr_err_q, sr_err_d;
  logic oob, dec_err, in_xfer, out_xfer;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic err_sticky_q, err_sticky_d;

  always_comb begin
    oh       = OUT_W'(1) << binary_in;
    therm    = (oh << 1) - OUT_W'(1);
    oob      = 32'(binary_in) >= OUT_W;
    raw      = mode == 2'b01 ? therm : mode == 2'b10 ? ~oh : oh;
    dec_word = (!enable || oob) ? {OUT_W{mode == 2'b10}} : raw;
    dec_err  = enable && (oob || mode == 2'b11);
  end

  always_comb begin
    in_xfer    = in_valid && in_ready_q;
    out_xfer   = out_valid_q && out_ready;
    state_d    = state_q;
    out_word_d = out_word_q;
    out_err_d  = out_err_q;
    sr_word_d  = sr_word_q;
    sr_err_d   = sr_err_q;
    unique case (state_q)
      EMPTY: if (in_xfer) begin
        state_d    = ONE;
        out_word_d = dec_word;
        out_err_d  = dec_err;
      end
      ONE: if (in_xfer && out_xfer) begin
        out_word_d = dec_word;
        out_err_d  = dec_err;
      end else if (in_xfer) begin
        state_d   = TWO;
        sr_word_d = dec_word;
        sr_err_d  = dec_err;
      end else if (out_xfer) begin
        state_d = EMPTY;
      end
      TWO: if (out_xfer) begin
        state_d    = ONE;
        out_word_d = sr_word_q;
        out_err_d  = sr_err_q;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d   = state_d != TWO;
    out_valid_d  = state_d != EMPTY;
    beat_cnt_d   = beat_cnt_q + CNT_W'(out_xfer);
    err_sticky_d = (out_xfer && out_err_q) || (err_sticky_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      out_err_q    <= 1'b0;
      sr_word_q    <= '0;
      sr_err_q     <= 1'b0;
      beat_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      out_err_q    <= out_err_d;
      sr_word_q    <= sr_word_d;
      sr_err_q     <= sr_err_d;
      beat_cnt_q   <= beat_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign decoder_out = out_word_q;
  assign range_err   = out_err_q;
  assign beat_cnt    = beat_cnt_q;
  assign err_sticky  = err_sticky_q;
endmodule
